cordic_phase_quadrant: RTL

Full-circle NCO wrapper around the first-quadrant `cordic` pipeline.
- Upstream side: phase accumulator; splits the phase into a 2-bit quadrant and a 15-bit in-quadrant angle `z_tgt` that drives `cordic`.
- Downstream side: consumes `cordic` `x_out`/`y_out` after the matched pipeline latency and rotates them into the correct quadrant.
- Result: signed cos/sin over the full 0..2π range, with a valid strobe.

---
 rtl/cordic_pkg.sv | 30 +++
 rtl/cordic_phase_quadrant_if.sv | 26 ++
 rtl/cordic_quad_delay.sv | 31 +++
 rtl/cordic_phase_quadrant.sv | 114 +++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the full-circle CORDIC wrapper.
package cordic_pkg;

  localparam int D_WIDTH    = 16;
  localparam int CORDIC_LAT = D_WIDTH - 1;
  localparam int PHASE_W    = D_WIDTH + 1;
  localparam int Z_W        = D_WIDTH - 1;
  localparam int S_W        = D_WIDTH + 1;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  typedef logic signed [S_W-1:0] sample_t;

  // Tag that travels alongside a sample while cordic computes it.
  typedef struct packed {
    logic      valid;
    quadrant_t quad;
  } qv_t;

  // The top two phase bits select the quadrant.
  function automatic quadrant_t phase_quadrant(input logic [PHASE_W-1:0] ph);
    return quadrant_t'(ph[PHASE_W-1 -: 2]);
  endfunction

endpackage

// File: rtl/cordic_phase_quadrant_if.sv
// Bus between the NCO wrapper, its controller and the cordic pipeline.
interface cordic_phase_quadrant_if;
  import cordic_pkg::*;

  logic               i_in_valid;
  logic               i_sync_clr;
  logic [PHASE_W-1:0] i_fcw;
  logic [PHASE_W-1:0] i_pofs;
  logic [Z_W-1:0]     o_z_tgt;
  sample_t            i_x_in;
  sample_t            i_y_in;
  sample_t            o_cos_out;
  sample_t            o_sin_out;
  logic               o_out_valid;

  modport master (
    output i_in_valid, i_sync_clr, i_fcw, i_pofs, i_x_in, i_y_in,
    input  o_z_tgt, o_cos_out, o_sin_out, o_out_valid
  );

  modport slave (
    input  i_in_valid, i_sync_clr, i_fcw, i_pofs, i_x_in, i_y_in,
    output o_z_tgt, o_cos_out, o_sin_out, o_out_valid
  );

endinterface

// File: rtl/cordic_quad_delay.sv
// Shift register carrying {valid, quadrant} across the cordic latency.
module cordic_quad_delay
  import cordic_pkg::*;
#(
  parameter int DEPTH = CORDIC_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  qv_t  i_qv,
  output qv_t  o_qv
);

  qv_t r_pipe [DEPTH];

  // Shift every cycle; a flush drops every in-flight valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_qv;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      if (i_flush) begin
        for (int i = 0; i < DEPTH; i++) r_pipe[i].valid <= 1'b0;
      end
    end
  end

  assign o_qv = r_pipe[DEPTH-1];

endmodule

// File: rtl/cordic_phase_quadrant.sv
// Full-circle NCO around a first-quadrant cordic: phase accumulation and
// quadrant split on the way in, quadrant rotation on the way out.
module cordic_phase_quadrant
  import cordic_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  cordic_phase_quadrant_if.slave bus
);

  logic [PHASE_W-1:0] r_acc;
  logic [Z_W-1:0]     r_z_tgt;
  qv_t                r_qv0;
  logic [PHASE_W-1:0] w_phase;
  qv_t                w_qv_dly;
  qv_t                r_qv_al;
  sample_t            r_x_al;
  sample_t            r_y_al;
  sample_t            w_cos;
  sample_t            w_sin;
  sample_t            r_cos;
  sample_t            r_sin;
  logic               r_out_valid;

  // Offset uses the accumulator value before this issue's step.
  assign w_phase = r_acc + bus.i_pofs;

  // Issue stage: advance the accumulator and launch one angle into cordic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_z_tgt <= '0;
      r_qv0   <= '0;
    end else if (bus.i_sync_clr) begin
      r_acc       <= '0;
      r_qv0.valid <= 1'b0;
    end else if (bus.i_in_valid) begin
      r_acc   <= r_acc + bus.i_fcw;
      r_z_tgt <= w_phase[Z_W-1:0];
      r_qv0   <= '{valid: 1'b1, quad: phase_quadrant(w_phase)};
    end else begin
      r_qv0.valid <= 1'b0;
    end
  end

  assign bus.o_z_tgt = r_z_tgt;

  cordic_quad_delay #(
    .DEPTH (CORDIC_LAT)
  ) u_quad_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.i_sync_clr),
    .i_qv    (r_qv0),
    .o_qv    (w_qv_dly)
  );

  // Alignment register: cordic result paired with the quadrant it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_al  <= '0;
      r_y_al  <= '0;
      r_qv_al <= '0;
    end else begin
      r_x_al        <= bus.i_x_in;
      r_y_al        <= bus.i_y_in;
      r_qv_al.quad  <= w_qv_dly.quad;
      r_qv_al.valid <= w_qv_dly.valid & ~bus.i_sync_clr;
    end
  end

  // Rotate the first-quadrant vector into its quadrant; inputs never exceed
  // 1.0, so negation cannot overflow the sample width.
  always_comb begin
    w_cos = r_x_al;
    w_sin = r_y_al;
    unique case (r_qv_al.quad)
      Q0: begin
        w_cos = r_x_al;
        w_sin = r_y_al;
      end
      Q1: begin
        w_cos = -r_y_al;
        w_sin = r_x_al;
      end
      Q2: begin
        w_cos = -r_x_al;
        w_sin = -r_y_al;
      end
      Q3: begin
        w_cos = r_y_al;
        w_sin = -r_x_al;
      end
    endcase
  end

  // Output stage: values refresh every cycle, valid follows the tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cos       <= '0;
      r_sin       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_cos       <= w_cos;
      r_sin       <= w_sin;
      r_out_valid <= r_qv_al.valid & ~bus.i_sync_clr;
    end
  end

  assign bus.o_cos_out   = r_cos;
  assign bus.o_sin_out   = r_sin;
  assign bus.o_out_valid = r_out_valid;

endmodule
